// File: rtl/m_cache_pkg.sv
// rtl/m_cache_pkg.sv - shared cache geometry, refill FSM encoding and line packing
package m_cache_pkg;

  localparam int ADDR_W = 32;
  localparam int TAG_W  = 24;
  localparam int IDX_W  = 5;
  localparam int WORD_W = 32;
  localparam int LINE_W = 1 + TAG_W + 2 * WORD_W;
  localparam int DEPTH  = 2 ** IDX_W;
  localparam int OFF_W  = ADDR_W - TAG_W - IDX_W;
  localparam int LADR_W = ADDR_W - OFF_W;
  localparam int CNT_W  = 16;

  // Byte offsets of the two words of a line within main memory.
  localparam logic [OFF_W-1:0] OFF_D2 = OFF_W'(0);
  localparam logic [OFF_W-1:0] OFF_D1 = OFF_W'(4);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH0 = 3'd1,
    ST_FETCH1 = 3'd2,
    ST_WRITE  = 3'd3,
    ST_FLUSH  = 3'd4
  } state_e;

  // Valid line layout {v, tag, d1, d2} as stored by the cache array.
  function automatic logic [LINE_W-1:0] pack_line(input logic [TAG_W-1:0]  tag,
                                                  input logic [WORD_W-1:0] d1,
                                                  input logic [WORD_W-1:0] d2);
    return {1'b1, tag, d1, d2};
  endfunction

endpackage

// File: rtl/m_sat_counter.sv
// rtl/m_sat_counter.sv - saturating up-counter with asynchronous active-high reset
module m_sat_counter #(
  parameter int            W       = 16,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Step by one on inc_i, but stick at all-ones instead of wrapping.
  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end
  end

  // Count register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/m_cache_refill_controller.sv
// rtl/m_cache_refill_controller.sv - miss refill and flush sweep engine for the direct-mapped two-word cache
module m_cache_refill_controller
  import m_cache_pkg::*;
#(
  parameter logic [CNT_W-1:0] MISS_CNT_RST = '0  // reset value of w_miss_count
) (
  input  logic              w_clock,
  input  logic              w_reset,
  input  logic              w_req,
  input  logic [ADDR_W-1:0] w_address,
  input  logic              w_hit,
  input  logic              w_flush,
  output logic              w_stall,
  output logic              w_mem_req,
  output logic [ADDR_W-1:0] w_mem_addr,
  input  logic              w_mem_ack,
  input  logic [WORD_W-1:0] w_mem_rdata,
  output logic [IDX_W-1:0]  w_wa,
  output logic              w_we,
  output logic [LINE_W-1:0] w_wd,
  output logic [CNT_W-1:0]  w_miss_count
);

  state_e              state_q, state_d;
  logic [LADR_W-1:0]   line_q, line_d;       // missing line address, A[31:3]
  logic [WORD_W-1:0]   d1_q, d1_d;
  logic [WORD_W-1:0]   d2_q, d2_d;
  logic [IDX_W-1:0]    flush_idx_q, flush_idx_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                miss_start;
  logic                ack_ok;

  // Byte offset of the requester address is irrelevant: whole lines are refilled.
  logic unused_addr_off;
  assign unused_addr_off = ^w_address[OFF_W-1:0];

  // An ack only counts while a request is actually outstanding.
  assign ack_ok = w_mem_ack & mem_req_q;

  // Next state, capture and memory request registers; flush beats a miss in IDLE.
  always_comb begin
    state_d     = state_q;
    line_d      = line_q;
    d1_d        = d1_q;
    d2_d        = d2_q;
    flush_idx_d = flush_idx_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    miss_start  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_flush) begin
          state_d     = ST_FLUSH;
          flush_idx_d = '0;
        end else if (w_req && !w_hit) begin
          miss_start = 1'b1;
          line_d     = w_address[ADDR_W-1:OFF_W];
          mem_req_d  = 1'b1;
          mem_addr_d = {w_address[ADDR_W-1:OFF_W], OFF_D2};
          state_d    = ST_FETCH0;
        end
      end
      ST_FETCH0: begin
        if (ack_ok) begin
          d2_d       = w_mem_rdata;
          mem_addr_d = {line_q, OFF_D1};
          state_d    = ST_FETCH1;
        end
      end
      ST_FETCH1: begin
        if (ack_ok) begin
          d1_d      = w_mem_rdata;
          mem_req_d = 1'b0;
          state_d   = ST_WRITE;
        end
      end
      ST_WRITE: begin
        state_d = ST_IDLE;
      end
      ST_FLUSH: begin
        flush_idx_d = flush_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        if (flush_idx_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any refill or sweep in flight.
  always_ff @(posedge w_clock or posedge w_reset) begin
    if (w_reset) begin
      state_q     <= ST_IDLE;
      line_q      <= '0;
      d1_q        <= '0;
      d2_q        <= '0;
      flush_idx_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
    end else begin
      state_q     <= state_d;
      line_q      <= line_d;
      d1_q        <= d1_d;
      d2_q        <= d2_d;
      flush_idx_q <= flush_idx_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
    end
  end

  // Cache write port: install the fetched line or clear one entry per sweep cycle.
  always_comb begin
    w_we = 1'b0;
    w_wa = '0;
    w_wd = '0;
    case (state_q)
      ST_WRITE: begin
        w_we = 1'b1;
        w_wa = line_q[IDX_W-1:0];
        w_wd = pack_line(line_q[LADR_W-1:IDX_W], d1_q, d2_q);
      end
      ST_FLUSH: begin
        w_we = 1'b1;
        w_wa = flush_idx_q;
      end
      default: begin
        w_we = 1'b0;
      end
    endcase
  end

  assign w_stall    = (state_q != ST_IDLE) | w_flush | (w_req & ~w_hit);
  assign w_mem_req  = mem_req_q;
  assign w_mem_addr = mem_addr_q;

  m_sat_counter #(
    .W       (CNT_W),
    .RST_VAL (MISS_CNT_RST)
  ) u_miss_cnt (
    .clk_i   (w_clock),
    .rst_i   (w_reset),
    .inc_i   (miss_start),
    .count_o (w_miss_count)
  );

endmodule
